riego_multizona_ctrl: RTL and testbench
=======================================

// Module: riego_multizona_ctrl
// PURPOSE
//  Parametrised multi-zone irrigation controller; successor of the single-zone top-level controller.
//  Per-zone soil sensors; one valve open at a time, round-robin fairness between zones.
//  Watering time scales with temperature; a 1 Hz tick is derived from CLK.
//  Dry-run protection: loss of water or a pump fault latches an alarm.
// PARAMETERS
//  N_ZONAS    4   number of irrigation zones (2..16)
//  TEMP_W     3   width of TEMP input
//  CNT_W      8   width of duration timer / RESTANTE
//  TICK_DIV   1   CLK cycles per second tick (1 => CLK already 1 Hz)
//  T_BASE     30  base watering time, seconds
//  T_STEP     10  extra seconds per TEMP unit
//  T_ENFRIA   60  per-zone lock-out after watering, seconds (RIEGO_ENFRIA_EN only)
// PORTS
//  CLK       in   1            system clock, rising edge
//  RST_N     in   1            synchronous reset, active-low
//  ON        in   1            master enable; 0 aborts and acknowledges alarm
//  HUMEDAD   in   N_ZONAS      per-zone soil sensor: 0 = dry (needs water), 1 = wet
//  AGUA      in   1            1 = water available in tank
//  BOMBA     in   1            1 = pump healthy
//  TEMP      in   TEMP_W       temperature level, unsigned
//  VALVULA   out  N_ZONAS      one-hot valve drive; all 0 outside RIEGO
//  BOMBA_ON  out  1            pump drive; 1 only in RIEGO
//  ZONA      out  $clog2(N_ZONAS)  index of zone being watered / last watered
//  RESTANTE  out  CNT_W        seconds remaining in current watering
//  ALARMA    out  1            latched dry-run / pump fault
// BEHAVIOUR
//  - All outputs registered; reset (RST_N=0 at edge): state REPOSO, VALVULA=0, BOMBA_ON=0,
//    ZONA=0, RESTANTE=0, ALARMA=0, round-robin pointer PTR=N_ZONAS-1, prescaler=0.
//  - Tick: prescaler counts 0..TICK_DIV-1, TICK pulses 1 cycle at TICK_DIV-1; cleared on entry to RIEGO.
//  - Duration = T_BASE + TEMP*T_STEP, saturated at 2^CNT_W-1; sampled once on entry to RIEGO.
//  - FSM (evaluated each cycle, priority top-down within a state):
//    REPOSO: ON&AGUA&BOMBA -> BUSCA; else stay.
//    BUSCA : ~ON -> REPOSO; ~AGUA|~BOMBA -> FALLO. Search zones PTR+1..PTR (mod N, wraps) for first
//            HUMEDAD[i]=0 (and not locked out); found -> RIEGO, ZONA=i, RESTANTE=duration; none -> stay.
//    RIEGO : VALVULA[ZONA]=1, BOMBA_ON=1 from the cycle after entry. ~ON -> REPOSO;
//            ~AGUA|~BOMBA -> FALLO; HUMEDAD[ZONA]=1 -> BUSCA (early stop);
//            TICK & RESTANTE==1 -> BUSCA with RESTANTE=0; TICK otherwise -> RESTANTE-1.
//            On any exit PTR=ZONA. ON=0 has priority over a fault in the same cycle.
//            Early stop and timer expiry in the same cycle: treated as one normal exit.
//    FALLO : VALVULA=0, BOMBA_ON=0, ALARMA=1; ~ON -> REPOSO and ALARMA=0 on that edge.
//  - Valve/pump drop to 0 on the same edge that leaves RIEGO (no overlap between zones;
//    minimum 1 cycle with all valves closed between consecutive zones via BUSCA).
//  - RESTANTE holds its value in BUSCA/REPOSO/FALLO; ZONA holds last zone.
//  - Duration 0 (impossible with T_BASE>0) is not supported; T_BASE>=1 required.
// CONFIGURATION
//  RIEGO_ENFRIA_EN defined: per-zone lock-out counter loaded with T_ENFRIA on leaving RIEGO
//    for that zone (any exit reason), decremented on every TICK in all states; zone skipped
//    by BUSCA while counter != 0; all counters cleared by reset.
//  Not defined: no lock-out logic; a zone still dry may be reselected immediately
//    (round-robin only guarantees other dry zones are served first).
// TESTING (TICK_DIV=1, N_ZONAS=4, defaults)
//  1 Reset: RST_N=0 2 cycles, arbitrary inputs -> all outputs 0, state REPOSO.
//  2 ON=1, AGUA=BOMBA=1, HUMEDAD=4'b1110, TEMP=2 -> VALVULA=4'b0001, RESTANTE=50,
//    counts to 0 over 50 ticks, then valves 0 for >=1 cycle, zone 0 reselected.
//  3 HUMEDAD=4'b0000 -> zones served in order 0,1,2,3,0; each for T_BASE+TEMP*T_STEP ticks.
//  4 Mid-RIEGO HUMEDAD[ZONA] 0->1 -> VALVULA=0 next edge, next dry zone selected.
//  5 Mid-RIEGO AGUA=0 -> FALLO: VALVULA=0, BOMBA_ON=0, ALARMA=1; AGUA=1 alone keeps alarm;
//    ON=0 -> ALARMA=0, REPOSO. Also ON=0 and AGUA=0 same cycle -> REPOSO, ALARMA=0.
//  6 TEMP=7, CNT_W=6 -> duration saturates to 63; with RIEGO_ENFRIA_EN, HUMEDAD=4'b1110
//    -> zone 0 re-watered only after 60 idle ticks.

Source files
------------

// File: rtl/riego_multizona_ctrl.sv
// Multi-zone irrigation controller: round-robin zone search, temperature-scaled watering time,
// latched dry-run alarm. Define RIEGO_ENFRIA_EN for a per-zone lock-out after each watering.
module riego_multizona_ctrl #(
    parameter int N_ZONAS  = 4,
    parameter int TEMP_W   = 3,
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 1,
    parameter int T_BASE   = 30,
    parameter int T_STEP   = 10,
    parameter int T_ENFRIA = 60
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       ON,
    input  logic [N_ZONAS-1:0]         HUMEDAD,
    input  logic                       AGUA,
    input  logic                       BOMBA,
    input  logic [TEMP_W-1:0]          TEMP,
    output logic [N_ZONAS-1:0]         VALVULA,
    output logic                       BOMBA_ON,
    output logic [$clog2(N_ZONAS)-1:0] ZONA,
    output logic [CNT_W-1:0]           RESTANTE,
    output logic                       ALARMA
);
    localparam int          ZW      = $clog2(N_ZONAS);
    localparam int          PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned NZ      = N_ZONAS;
    localparam logic [31:0] DUR_MAX = (32'd1 << CNT_W) - 32'd1;

    typedef enum logic [1:0] {REPOSO, BUSCA, RIEGO, FALLO} estado_t;

    estado_t           state;
    logic [PW-1:0]     presc;
    logic [ZW-1:0]     ptr;
    logic [ZW-1:0]     sel;
    logic [ZW-1:0]     idx;
    int unsigned       pos;
    logic              found;
    logic              tick;
    logic              fallo_in;
    logic              expira;
    logic              salir;
    logic [31:0]       dur_full;
    logic [CNT_W-1:0]  dur;
    logic [N_ZONAS-1:0] bloq;

    always_comb begin
        tick     = (presc == PW'(TICK_DIV - 1));
        dur_full = 32'(T_BASE) + 32'(TEMP) * 32'(T_STEP);
        dur      = (dur_full > DUR_MAX) ? DUR_MAX[CNT_W-1:0] : dur_full[CNT_W-1:0];
        fallo_in = !AGUA || !BOMBA;
        expira   = tick && (RESTANTE == CNT_W'(1));
        salir    = (state == RIEGO) && (!ON || fallo_in || HUMEDAD[ZONA] || expira);
    end

    // Round-robin: scan PTR+1 .. PTR (wrapping), first dry and unlocked zone wins.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        pos   = 0;
        idx   = '0;
        for (int unsigned k = 1; k <= NZ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= NZ) pos = pos - NZ;
            idx = ZW'(pos);
            if (!found && !HUMEDAD[idx] && !bloq[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

`ifdef RIEGO_ENFRIA_EN
    localparam int EW = $clog2(T_ENFRIA + 1);
    logic [EW-1:0] enfria [N_ZONAS];

    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < NZ; i++) begin
            if (!RST_N) enfria[i] <= '0;
            else if (salir && ZONA == ZW'(i)) enfria[i] <= EW'(T_ENFRIA);
            else if (tick && enfria[i] != '0) enfria[i] <= enfria[i] - EW'(1);
        end
    end

    always_comb begin
        bloq = '0;
        for (int unsigned i = 0; i < NZ; i++) bloq[i] = (enfria[i] != '0);
    end
`else
    always_comb bloq = '0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= REPOSO;
            VALVULA  <= '0;
            BOMBA_ON <= 1'b0;
            ZONA     <= '0;
            RESTANTE <= '0;
            ALARMA   <= 1'b0;
            ptr      <= ZW'(N_ZONAS - 1);
            presc    <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            case (state)
                REPOSO: if (ON && AGUA && BOMBA) state <= BUSCA;
                BUSCA: begin
                    if (!ON) state <= REPOSO;
                    else if (fallo_in) begin
                        state  <= FALLO;
                        ALARMA <= 1'b1;
                    end else if (found) begin
                        state    <= RIEGO;
                        ZONA     <= sel;
                        RESTANTE <= dur;
                        VALVULA  <= N_ZONAS'(1) << sel;
                        BOMBA_ON <= 1'b1;
                        presc    <= '0;
                    end
                end
                RIEGO: begin
                    if (salir) begin
                        VALVULA  <= '0;
                        BOMBA_ON <= 1'b0;
                        ptr      <= ZONA;
                        if (!ON) state <= REPOSO;
                        else if (fallo_in) begin
                            state  <= FALLO;
                            ALARMA <= 1'b1;
                        end else begin
                            // early stop and expiry together collapse into one normal exit
                            state <= BUSCA;
                            if (expira) RESTANTE <= '0;
                        end
                    end else if (tick) begin
                        RESTANTE <= RESTANTE - CNT_W'(1);
                    end
                end
                FALLO: if (!ON) begin
                    state  <= REPOSO;
                    ALARMA <= 1'b0;
                end
                default: state <= REPOSO;
            endcase
        end
    end
endmodule

// File: tb/tb_riego_multizona_ctrl.sv
// Directed bench for riego_multizona_ctrl: default instance plus a CNT_W=6 instance for saturation.
module tb_riego_multizona_ctrl;
`ifdef RIEGO_ENFRIA_EN
    localparam int REARM = 61;
`else
    localparam int REARM = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       on;
    logic [3:0] humedad;
    logic       agua;
    logic       bomba;
    logic [2:0] temp;
    logic [3:0] valvula;
    logic       bomba_on;
    logic [1:0] zona;
    logic [7:0] restante;
    logic       alarma;

    logic       on6;
    logic [3:0] humedad6;
    logic [2:0] temp6;
    logic [3:0] valvula6;
    logic       bomba_on6;
    logic [1:0] zona6;
    logic [5:0] restante6;
    logic       alarma6;

    int checks;
    int errors;

    riego_multizona_ctrl dut (
        .CLK(clk), .RST_N(rst_n), .ON(on), .HUMEDAD(humedad), .AGUA(agua), .BOMBA(bomba),
        .TEMP(temp), .VALVULA(valvula), .BOMBA_ON(bomba_on), .ZONA(zona),
        .RESTANTE(restante), .ALARMA(alarma)
    );

    riego_multizona_ctrl #(.CNT_W(6)) dut6 (
        .CLK(clk), .RST_N(rst_n), .ON(on6), .HUMEDAD(humedad6), .AGUA(agua), .BOMBA(bomba),
        .TEMP(temp6), .VALVULA(valvula6), .BOMBA_ON(bomba_on6), .ZONA(zona6),
        .RESTANTE(restante6), .ALARMA(alarma6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        on6 = 1'b0; humedad6 = 4'b1111; temp6 = 3'd7;

        // 1: reset with arbitrary inputs
        rst_n = 1'b0; on = 1'b1; humedad = 4'b0000; agua = 1'b1; bomba = 1'b1; temp = 3'd5;
        step(2);
        check("rst_valvula", 32'(valvula), 0);
        check("rst_bomba_on", 32'(bomba_on), 0);
        check("rst_zona", 32'(zona), 0);
        check("rst_restante", 32'(restante), 0);
        check("rst_alarma", 32'(alarma), 0);
        check("rst6_valvula", 32'(valvula6), 0);

        // 2: single dry zone, TEMP=2 -> 50 s
        rst_n = 1'b1; humedad = 4'b1110; temp = 3'd2;
        step(2);
        check("t2_valvula", 32'(valvula), 4'b0001);
        check("t2_bomba_on", 32'(bomba_on), 1);
        check("t2_restante", 32'(restante), 50);
        step(1);
        check("t2_restante_dec", 32'(restante), 49);
        step(48);
        check("t2_restante_1", 32'(restante), 1);
        check("t2_valvula_hold", 32'(valvula), 4'b0001);
        step(1);
        check("t2_restante_0", 32'(restante), 0);
        check("t2_valvula_off", 32'(valvula), 0);
        check("t2_bomba_off", 32'(bomba_on), 0);
        step(REARM);
        check("t2_reselect_valvula", 32'(valvula), 4'b0001);
        check("t2_reselect_restante", 32'(restante), 50);

        // 3: all zones dry, TEMP=0 -> 30 s each, order 0,1,2,3,0
        rst_n = 1'b0; step(1);
        rst_n = 1'b1; humedad = 4'b0000; temp = 3'd0;
        step(2);
        for (int z = 0; z < 5; z++) begin
            check("t3_zona", 32'(zona), 32'(z % 4));
            check("t3_valvula", 32'(valvula), 32'(1) << (z % 4));
            check("t3_restante", 32'(restante), 30);
            if (z < 4) begin
                step(29);
                check("t3_restante_1", 32'(restante), 1);
                step(1);
                check("t3_gap", 32'(valvula), 0);
                step(1);
            end
        end

        // 4: early stop on zone 0
        step(5);
        check("t4_restante", 32'(restante), 25);
        humedad = 4'b0001;
        step(1);
        check("t4_valvula_off", 32'(valvula), 0);
        check("t4_restante_hold", 32'(restante), 25);
        step(1);
        check("t4_next_zona", 32'(zona), 1);
        check("t4_next_valvula", 32'(valvula), 4'b0010);

        // 5: water loss, alarm latch, acknowledge
        step(3);
        agua = 1'b0;
        step(1);
        check("t5_valvula", 32'(valvula), 0);
        check("t5_bomba_on", 32'(bomba_on), 0);
        check("t5_alarma", 32'(alarma), 1);
        agua = 1'b1;
        step(3);
        check("t5_alarma_latched", 32'(alarma), 1);
        check("t5_valvula_fallo", 32'(valvula), 0);
        on = 1'b0;
        step(1);
        check("t5_alarma_ack", 32'(alarma), 0);
        on = 1'b1;
        step(2);
        check("t5_resume_zona", 32'(zona), 2);
        check("t5_resume_valvula", 32'(valvula), 4'b0100);
        on = 1'b0; agua = 1'b0;
        step(1);
        check("t5_abort_valvula", 32'(valvula), 0);
        check("t5_abort_alarma", 32'(alarma), 0);
        on = 1'b1; agua = 1'b1;
        step(1);
        check("t5_busca_valvula", 32'(valvula), 0);
        step(1);
        check("t5_abort_zona", 32'(zona), 3);
        check("t5_abort_alarma2", 32'(alarma), 0);
        on = 1'b0;
        step(1);

        // 6: saturation on the CNT_W=6 instance, TEMP=7 -> 100 clipped to 63
        on6 = 1'b1; humedad6 = 4'b1110;
        step(2);
        check("t6_valvula", 32'(valvula6), 4'b0001);
        check("t6_restante_sat", 32'(restante6), 63);
        step(62);
        check("t6_restante_1", 32'(restante6), 1);
        step(1);
        check("t6_valvula_off", 32'(valvula6), 0);
        check("t6_restante_0", 32'(restante6), 0);
        if (REARM > 1) begin
            step(REARM - 1);
            check("t6_lockout", 32'(valvula6), 0);
            step(1);
        end else begin
            step(1);
        end
        check("t6_rearm_valvula", 32'(valvula6), 4'b0001);
        check("t6_rearm_restante", 32'(restante6), 63);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
